// File: rtl/pixel_stream_pkg.sv
// Shared types and constants for the pixel-stream transmitter: FSM states, pattern codes,
// the RGB888 pixel type and the colour-bar table.
package pixel_stream_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StActive,
      StHblank,
      StVblank
   } state_e;

   localparam logic [1:0] PAT_SOLID = 2'd0;
   localparam logic [1:0] PAT_BARS  = 2'd1;
   localparam logic [1:0] PAT_RAMP  = 2'd2;
   localparam logic [1:0] PAT_COUNT = 2'd3;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   // Index is the bar number; bit 2 drives red, bit 1 green, bit 0 blue.
   localparam rgb_t [7:0] BarColors = {
      24'hFFFFFF, 24'hFFFF00, 24'hFF00FF, 24'hFF0000,
      24'h00FFFF, 24'h00FF00, 24'h0000FF, 24'h000000
   };

endpackage

// File: rtl/pixel_pattern_gen.sv
// Combinational test-pattern source; the parent registers the result on each active tick.
module pixel_pattern_gen
   import pixel_stream_pkg::*;
#(
   parameter int unsigned DATA_W   = 24,
   parameter int unsigned H_ACTIVE = 8,
   parameter int unsigned XW       = 3,
   parameter int unsigned YW       = 3
) (
   input  logic [1:0]        pattern,
   input  logic [DATA_W-1:0] solid,
   input  logic [XW-1:0]     x,
   input  logic [YW-1:0]     y,
   input  logic [7:0]        frame_lsb,
   output logic [DATA_W-1:0] pixel
);

   logic [2:0]        bar_sel;
   logic [23:0]       bar_rgb;
   logic [DATA_W-1:0] pix_idx;

   assign bar_sel = 3'((32'(x) * 32'd8) / H_ACTIVE);
   assign bar_rgb = BarColors[bar_sel];
   assign pix_idx = DATA_W'(32'(y) * H_ACTIVE + 32'(x));

   always_comb begin
      pixel = solid;
      unique case (pattern)
         PAT_SOLID: pixel = solid;
         PAT_BARS:  pixel = DATA_W'(bar_rgb);
         PAT_RAMP:  pixel = DATA_W'({8'(y), 8'(x), frame_lsb});
         PAT_COUNT: pixel = pix_idx;
         default:   pixel = solid;
      endcase
   end

endmodule

// File: rtl/pixel_stream_tx.sv
// Raster pixel-stream source with blanking, frame/line markers and selectable test patterns.
// Define PIXEL_STREAM_TX_READY_EN to add pixel_ready back-pressure on active pixels.
module pixel_stream_tx
   import pixel_stream_pkg::*;
#(
   parameter int unsigned DATA_W   = 24,
   parameter int unsigned H_ACTIVE = 8,
   parameter int unsigned V_ACTIVE = 4,
   parameter int unsigned H_BLANK  = 2,
   parameter int unsigned V_BLANK  = 3,
   parameter int unsigned CLK_DIV  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              cont_mode,
   input  logic [1:0]        pattern_sel,
   input  logic [DATA_W-1:0] solid_color,
`ifdef PIXEL_STREAM_TX_READY_EN
   input  logic              pixel_ready,
`endif
   output logic [DATA_W-1:0] pixel_data,
   output logic              pixel_valid,
   output logic              line_start,
   output logic              frame_start,
   output logic              frame_done,
   output logic              busy,
   output logic [15:0]       frame_cnt
);

   localparam int unsigned XW        = $clog2(H_ACTIVE);
   localparam int unsigned YW        = $clog2(V_ACTIVE + 1);
   localparam int unsigned VbTicks   = V_BLANK * (H_ACTIVE + H_BLANK);
   localparam int unsigned BlankMax  = (VbTicks > H_BLANK) ? VbTicks : H_BLANK;
   localparam int unsigned BW        = $clog2(BlankMax + 1);
   localparam int unsigned DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   state_e            state_q, state_d;
   logic [DW-1:0]     div_q, div_d;
   logic [XW-1:0]     x_q, x_d;
   logic [YW-1:0]     y_q, y_d;
   logic [BW-1:0]     blank_q, blank_d;
   logic [1:0]        pat_q, pat_d;
   logic [DATA_W-1:0] solid_q, solid_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;
   logic [DATA_W-1:0] pixel_data_q, pixel_data_d;
   logic              pixel_valid_q, pixel_valid_d;
   logic              line_start_q, line_start_d;
   logic              frame_start_q, frame_start_d;
   logic              frame_done_q, frame_done_d;

   logic              tick, stall, advance, emit, frame_end;
   logic [DATA_W-1:0] pattern_pixel;

   assign tick = (div_q == DW'(CLK_DIV - 1));
`ifdef PIXEL_STREAM_TX_READY_EN
   // A pending pixel freezes the whole raster until it is accepted.
   assign stall = pixel_valid_q & ~pixel_ready;
`else
   assign stall = 1'b0;
`endif
   assign advance = tick & ~stall;

   pixel_pattern_gen #(
      .DATA_W   (DATA_W),
      .H_ACTIVE (H_ACTIVE),
      .XW       (XW),
      .YW       (YW)
   ) u_pattern (
      .pattern   (pat_q),
      .solid     (solid_q),
      .x         (x_q),
      .y         (y_q),
      .frame_lsb (frame_cnt_q[7:0]),
      .pixel     (pattern_pixel)
   );

   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      x_d         = x_q;
      y_d         = y_q;
      blank_d     = blank_q;
      pat_d       = pat_q;
      solid_d     = solid_q;
      frame_cnt_d = frame_cnt_q;
      emit        = 1'b0;
      frame_end   = 1'b0;

      if (state_q != StIdle && !stall) begin
         div_d = tick ? '0 : div_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            div_d = '0;
            if (start) begin
               state_d = StActive;
               x_d     = '0;
               y_d     = '0;
               pat_d   = pattern_sel;
               solid_d = solid_color;
            end
         end
         StActive: begin
            if (advance) begin
               emit = 1'b1;
               if (x_q == XW'(H_ACTIVE - 1)) begin
                  x_d     = '0;
                  blank_d = '0;
                  state_d = StHblank;
               end else begin
                  x_d = x_q + 1'b1;
               end
            end
         end
         StHblank: begin
            if (advance) begin
               if (blank_q == BW'(H_BLANK - 1)) begin
                  blank_d = '0;
                  if (y_q != YW'(V_ACTIVE - 1)) begin
                     y_d     = y_q + 1'b1;
                     state_d = StActive;
                  end else if (V_BLANK == 0) begin
                     frame_end = 1'b1;
                  end else begin
                     y_d     = y_q + 1'b1;
                     state_d = StVblank;
                  end
               end else begin
                  blank_d = blank_q + 1'b1;
               end
            end
         end
         StVblank: begin
            if (advance) begin
               if (blank_q == BW'(VbTicks - 1)) begin
                  frame_end = 1'b1;
               end else begin
                  blank_d = blank_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (frame_end) begin
         frame_cnt_d = frame_cnt_q + 1'b1;
         x_d         = '0;
         y_d         = '0;
         blank_d     = '0;
         if (cont_mode) begin
            state_d = StActive;
            pat_d   = pattern_sel;
            solid_d = solid_color;
         end else begin
            state_d = StIdle;
         end
      end

      frame_done_d  = frame_end;
      pixel_valid_d = stall ? 1'b1 : emit;
      line_start_d  = stall ? line_start_q : (emit && x_q == '0);
      frame_start_d = stall ? frame_start_q : (emit && x_q == '0 && y_q == '0);
      pixel_data_d  = emit ? pattern_pixel : pixel_data_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         div_q         <= '0;
         x_q           <= '0;
         y_q           <= '0;
         blank_q       <= '0;
         pat_q         <= '0;
         solid_q       <= '0;
         frame_cnt_q   <= '0;
         pixel_data_q  <= '0;
         pixel_valid_q <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         div_q         <= div_d;
         x_q           <= x_d;
         y_q           <= y_d;
         blank_q       <= blank_d;
         pat_q         <= pat_d;
         solid_q       <= solid_d;
         frame_cnt_q   <= frame_cnt_d;
         pixel_data_q  <= pixel_data_d;
         pixel_valid_q <= pixel_valid_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         frame_done_q  <= frame_done_d;
      end
   end

   assign pixel_data  = pixel_data_q;
   assign pixel_valid = pixel_valid_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign frame_done  = frame_done_q;
   assign busy        = (state_q != StIdle);
   assign frame_cnt   = frame_cnt_q;

endmodule
